// File: rtl/nd_2to1_arb.sv
// nd_2to1_arb: two-input round-robin merge node on 2-phase toggle links.
// Define NS_2TO1_REDUN_CHECK_EN to drop and count messages with a bad redun field.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1_arb #(
   parameter int ASZ = `NS_ADDRESS_SIZE,
   parameter int DSZ = `NS_DATA_SIZE,
   parameter int RSZ = `NS_REDUN_SIZE,
   parameter int MSZ = ASZ + DSZ + RSZ
) (
   input  logic           i_clk,
   input  logic           reset,
   output logic           ready,
   input  logic           rcv0_ck_req,
   output logic           rcv0_ck_ack,
   input  logic [MSZ-1:0] rcv0_data,
   input  logic           rcv1_ck_req,
   output logic           rcv1_ck_ack,
   input  logic [MSZ-1:0] rcv1_data,
   output logic           snd0_ck_req,
   input  logic           snd0_ck_ack,
   output logic [MSZ-1:0] snd0_data,
   output logic [7:0]     err_cnt
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t         state;
   logic [1:0]     req0_sy;
   logic [1:0]     req1_sy;
   logic [1:0]     ack_sy;
   logic           last1;
   logic           pend0;
   logic           pend1;
   logic           gnt0;
   logic           gnt1;
   logic           good;
   logic [MSZ-1:0] sel;

   assign pend0 = req0_sy[1] ^ rcv0_ck_ack;
   assign pend1 = req1_sy[1] ^ rcv1_ck_ack;
   // last1 set means input 1 won last, so input 0 takes a tie
   assign gnt0  = pend0 & (~pend1 | last1);
   assign gnt1  = pend1 & (~pend0 | ~last1);
   assign sel   = gnt1 ? rcv1_data : rcv0_data;

`ifdef NS_2TO1_REDUN_CHECK_EN
   assign good = sel[RSZ-1:0] ==
                 (sel[MSZ-ASZ +: RSZ] ^ sel[RSZ +: RSZ]);

   always_ff @(posedge i_clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (state == IDLE && (gnt0 | gnt1) && !good
                   && err_cnt != 8'hff) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign good    = 1'b1;
   assign err_cnt = '0;
`endif

   always_ff @(posedge i_clk) begin
      if (reset) begin
         state       <= IDLE;
         ready       <= 1'b0;
         req0_sy     <= '0;
         req1_sy     <= '0;
         ack_sy      <= '0;
         last1       <= 1'b1;
         rcv0_ck_ack <= 1'b0;
         rcv1_ck_ack <= 1'b0;
         snd0_ck_req <= 1'b0;
         snd0_data   <= '0;
      end else begin
         ready   <= 1'b1;
         req0_sy <= {req0_sy[0], rcv0_ck_req};
         req1_sy <= {req1_sy[0], rcv1_ck_req};
         ack_sy  <= {ack_sy[0], snd0_ck_ack};
         unique case (state)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  if (gnt0)
                     rcv0_ck_ack <= ~rcv0_ck_ack;
                  else
                     rcv1_ck_ack <= ~rcv1_ck_ack;
                  last1 <= gnt1;
                  if (good) begin
                     snd0_data   <= sel;
                     snd0_ck_req <= ~snd0_ck_req;
                     state       <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (ack_sy[1] == snd0_ck_req)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
